// File: rtl/switch_pkg.sv
// ---------------------------------------------------------------------------
// switch_pkg
// Shared types and constants for the switch test-harness packet generator.
//   pg_state_e   : generator FSM states
//   HDR_WORDS    : number of header words ahead of the payload
//   PAYLOAD_ONES : payload word value
//   meta_t       : metadata entry layout for the default configuration
//   port_to_mac  : locally administered MAC address for a switch port
// ---------------------------------------------------------------------------
package switch_pkg;

   typedef enum logic [3:0] {
      IDLE,
      FETCH,
      LOAD,
      H0,
      H1,
      H2,
      H3,
      H4,
      H5,
      PAYLOAD
   } pg_state_e;

   localparam int          HDR_WORDS    = 6;
   localparam logic [31:0] PAYLOAD_ONES = '1;

   // Entry layout for N_PORTS=4, LEN_W=6, META_WIDTH=32, MSB first.
   typedef struct packed {
      logic [1:0]  src;
      logic [1:0]  dst;
      logic [5:0]  len_m1;
      logic [21:0] tag;
   } meta_t;

   function automatic logic [47:0] port_to_mac(input logic [7:0] port);
      return {40'h02_00_00_00_00, port};
   endfunction

endpackage

// File: rtl/simple_dual_port_mem.sv
// ---------------------------------------------------------------------------
// simple_dual_port_mem
// One write port, one read port, synchronous read with 1-cycle latency.
//   clk      : clock
//   wr_en    : write wr_data at wr_addr
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : capture mem[rd_addr] into rd_data on the next edge
//   rd_addr  : read address
//   rd_data  : read data, held while rd_en is low
// ---------------------------------------------------------------------------
module simple_dual_port_mem #(
   parameter  int DEPTH = 1024,
   parameter  int WIDTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // NOTE: storage arrays carry no reset so they map onto RAM macros; readers
   // must never consume an entry before it has been written.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data_q <= mem[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/packet_gen_mp.sv
// ---------------------------------------------------------------------------
// packet_gen_mp
// Queues host-written packet metadata in a circular buffer and emits one
// 32-bit word stream per entry: H0..H5 header words then all-ones payload.
//   clk, reset     : clock, asynchronous active-high reset
//   meta_in(_en)   : metadata write {src, dst, len_m1, tag}
//   experimenting  : generation enable, sampled only between packets
//   out_ready      : downstream handshake
//   out_valid/data/sop/eop/dst : registered packet stream
//   meta_full/meta_empty       : buffer occupancy flags
//   drop_cnt       : writes dropped while full (saturating)
//   sent_cnt       : packets whose EOP word handshook (wrapping)
// ---------------------------------------------------------------------------
module packet_gen_mp
   import switch_pkg::*;
#(
   parameter  int N_PORTS     = 4,
   parameter  int DEPTH       = 1024,
   parameter  int META_WIDTH  = 32,
   parameter  int LEN_W       = 6,
   parameter  int BLOCK_BYTES = 32,
   parameter  int TS_W        = 32,
   localparam int PORT_W      = $clog2(N_PORTS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [META_WIDTH-1:0] meta_in,
   input  logic                  meta_in_en,
   input  logic                  experimenting,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [31:0]           out_data,
   output logic                  out_sop,
   output logic                  out_eop,
   output logic [PORT_W-1:0]     out_dst,
   output logic                  meta_full,
   output logic                  meta_empty,
   output logic [15:0]           drop_cnt,
   output logic [31:0]           sent_cnt
);

   localparam int AW    = $clog2(DEPTH);
   localparam int WPB   = BLOCK_BYTES / 4;
   localparam int RW    = LEN_W + $clog2(WPB) + 2;
   localparam int TAG_W = META_WIDTH - 2 * PORT_W - LEN_W;

   function automatic logic [RW-1:0] words_of(input logic [LEN_W-1:0] l);
      logic [RW-1:0] w;
      w = (RW'(l) + RW'(1)) * RW'(WPB);
      if (w < RW'(HDR_WORDS + 2)) w = RW'(HDR_WORDS + 2);
      return w;
   endfunction

   function automatic logic [15:0] bytes_of(input logic [LEN_W-1:0] l);
      return 16'((32'(l) + 32'd1) * 32'(BLOCK_BYTES));
   endfunction

   pg_state_e         state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [TS_W-1:0]   ts_q, ts_d, ts_lat_q, ts_lat_d;
   logic [PORT_W-1:0] src_q, src_d, dst_q, dst_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [RW-1:0]     rem_q, rem_d;
   logic [15:0]       drop_q, drop_d;
   logic [31:0]       sent_q, sent_d;
   logic              out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
   logic [31:0]       out_data_q, out_data_d;
   logic [PORT_W-1:0] out_dst_q, out_dst_d;

   logic                  full, empty, wr_en, pop, hs;
   logic [META_WIDTH-1:0] rd_data;
   logic [47:0]           dmac, smac;
   logic [63:0]           ts64;
   logic                  unused_tag;

   assign full  = (count_q == (AW + 1)'(DEPTH));
   assign empty = (count_q == '0);
   assign hs    = out_valid_q && out_ready;

   simple_dual_port_mem #(.DEPTH(DEPTH), .WIDTH(META_WIDTH)) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (meta_in),
      .rd_en   (pop),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

   assign unused_tag = ^rd_data[TAG_W-1:0];

   // NOTE: every always_comb output gets a default first so no path leaves a
   // variable unassigned, which would infer a latch.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ts_d     = ts_q + TS_W'(1);
      ts_lat_d = ts_lat_q;
      src_d    = src_q;
      dst_d    = dst_q;
      len_d    = len_q;
      rem_d    = rem_q;
      drop_d   = drop_q;
      sent_d   = sent_q;
      pop      = 1'b0;

      // Full is judged on the pre-write count, so a same-cycle pop never
      // rescues a write that arrives while full.
      wr_en = meta_in_en && !full;
      if (meta_in_en && full && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);

      if (hs) rem_d = rem_q - RW'(1);

      case (state_q)
         IDLE:  if (experimenting && !empty) state_d = FETCH;
         FETCH: begin
            pop      = 1'b1;
            rd_ptr_d = rd_ptr_q + AW'(1);
            state_d  = LOAD;
         end
         LOAD: begin
            src_d    = rd_data[META_WIDTH-1 -: PORT_W];
            dst_d    = rd_data[META_WIDTH-1-PORT_W -: PORT_W];
            len_d    = rd_data[META_WIDTH-1-2*PORT_W -: LEN_W];
            ts_lat_d = ts_q;
            rem_d    = words_of(rd_data[META_WIDTH-1-2*PORT_W -: LEN_W]);
            state_d  = H0;
         end
         H0: if (hs) state_d = H1;
         H1: if (hs) state_d = H2;
         H2: if (hs) state_d = H3;
         H3: if (hs) state_d = H4;
         H4: if (hs) state_d = H5;
         H5: if (hs) state_d = PAYLOAD;
         PAYLOAD: begin
            if (hs && rem_q <= RW'(1)) begin
               sent_d  = sent_q + 32'd1;
               state_d = (experimenting && !empty) ? FETCH : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      unique case ({wr_en, pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase

      // Outputs are decoded from next-state values so they register in step
      // with the state and hold unchanged while stalled.
      dmac        = port_to_mac(8'(dst_d));
      smac        = port_to_mac(8'(src_d));
      ts64        = 64'(ts_lat_d);
      out_valid_d = 1'b1;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
      out_dst_d   = dst_d;
      case (state_d)
         H0: begin
            out_data_d = {bytes_of(len_d), dmac[47:32]};
            out_sop_d  = 1'b1;
         end
         H1:      out_data_d = dmac[31:0];
         H2:      out_data_d = ts64[31:0];
         H3:      out_data_d = ts64[63:32];
         H4:      out_data_d = {16'h0000, smac[47:32]};
         H5:      out_data_d = smac[31:0];
         PAYLOAD: begin
            out_data_d = PAYLOAD_ONES;
            out_eop_d  = (rem_d == RW'(1));
         end
         default: begin
            out_valid_d = 1'b0;
            out_data_d  = 32'h0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ts_q        <= '0;
         ts_lat_q    <= '0;
         src_q       <= '0;
         dst_q       <= '0;
         len_q       <= '0;
         rem_q       <= '0;
         drop_q      <= '0;
         sent_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_dst_q   <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ts_q        <= ts_d;
         ts_lat_q    <= ts_lat_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         len_q       <= len_d;
         rem_q       <= rem_d;
         drop_q      <= drop_d;
         sent_q      <= sent_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
         out_dst_q   <= out_dst_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_sop    = out_sop_q;
   assign out_eop    = out_eop_q;
   assign out_dst    = out_dst_q;
   assign meta_full  = full;
   assign meta_empty = empty;
   assign drop_cnt   = drop_q;
   assign sent_cnt   = sent_q;

endmodule

// File: tb/tb_packet_gen_mp.sv
// ---------------------------------------------------------------------------
// tb_packet_gen_mp
// Directed bench for packet_gen_mp with default parameters. Expected packet
// contents come from the length/MAC rules, computed here per entry.
// ---------------------------------------------------------------------------
module tb_packet_gen_mp;
   import switch_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] meta_in;
   logic        meta_in_en;
   logic        experimenting;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_sop;
   logic        out_eop;
   logic [1:0]  out_dst;
   logic        meta_full;
   logic        meta_empty;
   logic [15:0] drop_cnt;
   logic [31:0] sent_cnt;

   packet_gen_mp dut (
      .clk           (clk),
      .reset         (reset),
      .meta_in       (meta_in),
      .meta_in_en    (meta_in_en),
      .experimenting (experimenting),
      .out_ready     (out_ready),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_sop       (out_sop),
      .out_eop       (out_eop),
      .out_dst       (out_dst),
      .meta_full     (meta_full),
      .meta_empty    (meta_empty),
      .drop_cnt      (drop_cnt),
      .sent_cnt      (sent_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Captured packet
   logic [31:0] pkt_w [0:1023];
   int          pkt_n, sop_cnt, sop_idx, eop_cnt, eop_idx, hold_bad, dst_bad;
   logic [1:0]  pkt_dst;
   logic        timed_out;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input int s, input int d, input int l, input int t);
      meta_t m;
      m.src    = 2'(s);
      m.dst    = 2'(d);
      m.len_m1 = 6'(l);
      m.tag    = 22'(t);
      return m;
   endfunction

   task automatic write_entry(input int s, input int d, input int l);
      @(negedge clk);
      meta_in    = mk(s, d, l, 0);
      meta_in_en = 1'b1;
      @(negedge clk);
      meta_in_en = 1'b0;
   endtask

   // Collects one packet; optionally toggles out_ready each cycle and drops
   // experimenting when word drop_at is accepted.
   task automatic recv_pkt(input bit toggle, input int drop_at, input int budget);
      bit          phase, stalled, done;
      logic [36:0] held;
      phase = 1'b1; stalled = 1'b0; done = 1'b0; held = '0;
      pkt_n = 0; sop_cnt = 0; sop_idx = -1; eop_cnt = 0; eop_idx = -1;
      hold_bad = 0; dst_bad = 0; pkt_dst = '0;
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge clk);
         if (toggle) begin
            out_ready = phase;
            phase     = !phase;
         end else begin
            out_ready = 1'b1;
         end
         if (stalled && {out_valid, out_sop, out_eop, out_dst, out_data} !== held) hold_bad++;
         stalled = 1'b0;
         if (out_valid === 1'b1) begin
            if (out_ready) begin
               if (pkt_n == 0) pkt_dst = out_dst;
               else if (out_dst !== pkt_dst) dst_bad++;
               pkt_w[pkt_n] = out_data;
               if (out_sop === 1'b1) begin sop_cnt++; sop_idx = pkt_n; end
               if (out_eop === 1'b1) begin eop_cnt++; eop_idx = pkt_n; done = 1'b1; end
               if (pkt_n == drop_at) experimenting = 1'b0;
               if (pkt_n < 1023) pkt_n++;
            end else begin
               stalled = 1'b1;
               held    = {out_valid, out_sop, out_eop, out_dst, out_data};
            end
         end
      end
      timed_out = !done;
      out_ready = 1'b1;
   endtask

   task automatic check_pkt(input string tag, input int s, input int d, input int l);
      int          words, bytes, ones_bad;
      logic [31:0] h0;
      words = (l + 1) * 8;
      if (words < 8) words = 8;
      bytes = (l + 1) * 32;
      h0    = {bytes[15:0], 16'h0200};
      ones_bad = 0;
      for (int k = 6; k < pkt_n; k++) if (pkt_w[k] !== 32'hFFFF_FFFF) ones_bad++;
      chk({tag, " timeout"}, 32'(timed_out), 32'd0);
      chk({tag, " words"}, pkt_n, words);
      chk({tag, " H0"}, pkt_w[0], h0);
      chk({tag, " H1"}, pkt_w[1], 32'(d));
      chk({tag, " H3"}, pkt_w[3], 32'h0);
      chk({tag, " H4"}, pkt_w[4], 32'h0000_0200);
      chk({tag, " H5"}, pkt_w[5], 32'(s));
      chk({tag, " payload"}, ones_bad, 0);
      chk({tag, " sop count"}, sop_cnt, 1);
      chk({tag, " sop index"}, sop_idx, 0);
      chk({tag, " eop count"}, eop_cnt, 1);
      chk({tag, " eop index"}, eop_idx, words - 1);
      chk({tag, " dst"}, 32'(pkt_dst), 32'(d));
      chk({tag, " dst stable"}, dst_bad, 0);
      chk({tag, " hold"}, hold_bad, 0);
   endtask

   initial begin
      int vcnt, hs_n;
      bit hit;
      reset = 1'b1; meta_in = '0; meta_in_en = 1'b0; experimenting = 1'b0; out_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_data", out_data, 32'h0);
      chk("rst sop/eop", {30'd0, out_sop, out_eop}, 32'd0);
      chk("rst out_dst", 32'(out_dst), 32'd0);
      chk("rst meta_full", 32'(meta_full), 32'd0);
      chk("rst meta_empty", 32'(meta_empty), 32'd1);
      chk("rst drop_cnt", 32'(drop_cnt), 32'd0);
      chk("rst sent_cnt", sent_cnt, 32'd0);
      reset = 1'b0;

      // Test 1: minimal packet
      write_entry(1, 2, 0);
      chk("t1 not empty", 32'(meta_empty), 32'd0);
      experimenting = 1'b1;
      recv_pkt(1'b0, -1, 100);
      check_pkt("t1", 1, 2, 0);
      @(negedge clk);
      chk("t1 sent_cnt", sent_cnt, 32'd1);
      chk("t1 meta_empty", 32'(meta_empty), 32'd1);
      chk("t1 idle valid", 32'(out_valid), 32'd0);

      // Test 2: longest packet
      write_entry(3, 1, 63);
      recv_pkt(1'b0, -1, 700);
      check_pkt("t2", 3, 1, 63);
      @(negedge clk);
      chk("t2 sent_cnt", sent_cnt, 32'd2);

      // Test 3: 1010 backpressure
      write_entry(1, 2, 0);
      recv_pkt(1'b1, -1, 200);
      check_pkt("t3", 1, 2, 0);
      @(negedge clk);
      chk("t3 sent_cnt", sent_cnt, 32'd3);

      // Test 5: enable dropped mid-packet
      experimenting = 1'b0;
      write_entry(2, 3, 1);
      write_entry(0, 1, 0);
      experimenting = 1'b1;
      recv_pkt(1'b0, 3, 100);
      check_pkt("t5a", 2, 3, 1);
      vcnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid !== 1'b0) vcnt++;
      end
      chk("t5 idle valid", vcnt, 0);
      chk("t5 entry kept", 32'(meta_empty), 32'd0);
      chk("t5 sent_cnt", sent_cnt, 32'd4);
      experimenting = 1'b1;
      recv_pkt(1'b0, -1, 100);
      check_pkt("t5b", 0, 1, 0);

      // Test 4: overfill, drops, then drain in write order across the wrap
      experimenting = 1'b0;
      for (int i = 0; i < 1027; i++) begin
         @(negedge clk);
         meta_in    = mk(i & 3, (i >> 2) & 3, (i >> 4) & 1, i);
         meta_in_en = 1'b1;
      end
      @(negedge clk);
      meta_in_en = 1'b0;
      chk("t4 meta_full", 32'(meta_full), 32'd1);
      chk("t4 drop_cnt", 32'(drop_cnt), 32'd3);
      experimenting = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         recv_pkt(1'b0, -1, 64);
         check_pkt($sformatf("t4 pkt%0d", i), i & 3, (i >> 2) & 3, (i >> 4) & 1);
      end
      @(negedge clk);
      chk("t4 meta_empty", 32'(meta_empty), 32'd1);
      chk("t4 sent_cnt", sent_cnt, 32'd1029);
      chk("t4 idle valid", 32'(out_valid), 32'd0);

      // Test 6: async reset in the middle of the payload
      write_entry(2, 1, 1);
      hs_n = 0; hit = 1'b0;
      for (int c = 0; c < 60 && !hit; c++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (hs_n == 8) begin
               hit   = 1'b1;
               reset = 1'b1;
               #1;
               chk("t6 out_valid", 32'(out_valid), 32'd0);
               chk("t6 out_data", out_data, 32'h0);
               chk("t6 sop/eop", {30'd0, out_sop, out_eop}, 32'd0);
               chk("t6 meta_empty", 32'(meta_empty), 32'd1);
               chk("t6 drop_cnt", 32'(drop_cnt), 32'd0);
               chk("t6 sent_cnt", sent_cnt, 32'd0);
            end
            hs_n++;
         end
      end
      chk("t6 reached payload", 32'(hit), 32'd1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6 post valid", 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
